// File: rtl/ifft8.sv
// ifft8: 8-point radix-2 inverse FFT, one butterfly per cycle, 1/2 per stage.
// Ports: clk, rst (sync, high), start, re_in/im_in (8 bins packed),
//        re_out/im_out (8 samples packed, registered), busy, done (pulse).
module ifft8 #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [8*DW-1:0] re_in,
  input  logic [8*DW-1:0] im_in,
  output logic [8*DW-1:0] re_out,
  output logic [8*DW-1:0] im_out,
  output logic          busy,
  output logic          done
);
  localparam int PW = DW + TW;
  localparam logic signed [TW-1:0] C45 = TW'(11585);
  localparam logic signed [DW+1:0] SMAX = (DW+2)'((2**(DW-1)) - 1);
  localparam logic signed [DW+1:0] SMIN = (DW+2)'(-(2**(DW-1)));

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t r_state, w_next;
  logic signed [DW-1:0] r_re [8];
  logic signed [DW-1:0] r_im [8];
  logic signed [DW-1:0] w_nre [8];
  logic signed [DW-1:0] w_nim [8];
  logic [1:0] r_s, r_b;
  logic r_busy, r_done;
  logic [8*DW-1:0] r_re_out, r_im_out;
  logic w_load, w_step, w_last;
  logic [2:0] w_span, w_j, w_top, w_bot;
  logic [1:0] w_k;
  logic signed [DW-1:0] w_xre, w_xim, w_bre, w_bim;
  logic signed [TW-1:0] w_wr, w_wi;
  logic signed [PW-1:0] w_prr, w_pii, w_pri, w_pir;
  logic signed [PW:0] w_mre, w_mim;
  logic signed [DW:0] w_tre, w_tim;
  logic signed [DW+1:0] w_are, w_aim, w_dre, w_dim;

  function automatic logic [2:0] rev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  function automatic logic signed [DW-1:0] sat(
    input logic signed [DW+1:0] v
  );
    if (v > SMAX) return DW'(SMAX);
    if (v < SMIN) return DW'(SMIN);
    return DW'(v);
  endfunction

  assign w_last = (r_state == S_CALC) && (r_s == 2'd2) && (r_b == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE: w_load = start;
      S_CALC: w_step = 1'b1;
      default: ;
    endcase
  end

  // Butterfly addressing for stage s, butterfly b
  assign w_span = 3'd1 << r_s;
  assign w_j    = {1'b0, r_b} & (w_span - 3'd1);
  assign w_top  = (({1'b0, r_b} >> r_s) << (r_s + 2'd1)) + w_j;
  assign w_bot  = w_top + w_span;
  assign w_k    = 2'(w_j << (2'd2 - r_s));

  assign w_xre = r_re[w_top];
  assign w_xim = r_im[w_top];
  assign w_bre = r_re[w_bot];
  assign w_bim = r_im[w_bot];

  // Only k=1 and k=3 need the multiplier; both share it
  assign w_wr  = (w_k == 2'd3) ? -C45 : C45;
  assign w_wi  = C45;
  assign w_prr = PW'(w_bre) * PW'(w_wr);
  assign w_pii = PW'(w_bim) * PW'(w_wi);
  assign w_pri = PW'(w_bre) * PW'(w_wi);
  assign w_pir = PW'(w_bim) * PW'(w_wr);
  assign w_mre = (PW+1)'(w_prr) - (PW+1)'(w_pii);
  assign w_mim = (PW+1)'(w_pri) + (PW+1)'(w_pir);

  always_comb begin
    w_tre = (DW+1)'(w_bre);
    w_tim = (DW+1)'(w_bim);
    unique case (1'b1)
      w_k == 2'd2: begin
        w_tre = -((DW+1)'(w_bim));
        w_tim = (DW+1)'(w_bre);
      end
      w_k[0]: begin
        w_tre = (DW+1)'(w_mre >>> (TW-2));
        w_tim = (DW+1)'(w_mim >>> (TW-2));
      end
      default: ;
    endcase
  end

  assign w_are = ((DW+2)'(w_xre) + (DW+2)'(w_tre)) >>> 1;
  assign w_aim = ((DW+2)'(w_xim) + (DW+2)'(w_tim)) >>> 1;
  assign w_dre = ((DW+2)'(w_xre) - (DW+2)'(w_tre)) >>> 1;
  assign w_dim = ((DW+2)'(w_xim) - (DW+2)'(w_tim)) >>> 1;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_nre[i] = r_re[i];
      w_nim[i] = r_im[i];
    end
    w_nre[w_top] = sat(w_are);
    w_nim[w_top] = sat(w_aim);
    w_nre[w_bot] = sat(w_dre);
    w_nim[w_bot] = sat(w_dim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_re_out <= '0;
      r_im_out <= '0;
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        for (int i = 0; i < 8; i++) begin
          r_re[i] <= re_in[int'(rev3(3'(i)))*DW +: DW];
          r_im[i] <= im_in[int'(rev3(3'(i)))*DW +: DW];
        end
        r_s    <= '0;
        r_b    <= '0;
        r_busy <= 1'b1;
      end
      if (w_step) begin
        for (int i = 0; i < 8; i++) begin
          r_re[i] <= w_nre[i];
          r_im[i] <= w_nim[i];
        end
        r_b <= r_b + 2'd1;
        if (r_b == 2'd3) r_s <= r_s + 2'd1;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          for (int i = 0; i < 8; i++) begin
            r_re_out[i*DW +: DW] <= w_nre[i];
            r_im_out[i*DW +: DW] <= w_nim[i];
          end
        end
      end
    end
  end

  assign re_out = r_re_out;
  assign im_out = r_im_out;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_ifft8.sv
// tb_ifft8: table of transforms checked against a real-valued IDFT model,
// plus start-while-busy, mid-run reset and back-to-back sequences.
module tb_ifft8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [8*DW-1:0] re_in, im_in, re_out, im_out;

  ifft8 #(.DW(DW), .TW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .re_in(re_in), .im_in(im_in),
    .re_out(re_out), .im_out(im_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int tol;
    int xr[8];
    int xi[8];
    int yr[8];
    int yi[8];
  } vec_t;

  typedef struct {
    vec_t v;
    int   c0;
  } sb_t;

  string nms[8] = '{"dc", "dcim", "flat", "tone1",
                    "tone7", "extreme", "satur", "rand"};
  vec_t tab[8];
  sb_t  sbq[$];
  int total = 0;
  int bad = 0;
  int n_done = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp, int tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  function automatic vec_t mk(int id, int tol);
    vec_t v;
    v.id = id;
    v.tol = tol;
    for (int k = 0; k < 8; k++) begin
      v.xr[k] = 0; v.xi[k] = 0;
      v.yr[k] = 0; v.yi[k] = 0;
    end
    return v;
  endfunction

  function automatic int rsat(real x);
    real f;
    f = $floor(x + 0.5);
    if (f > 32767.0) return 32767;
    if (f < -32768.0) return -32768;
    return $rtoi(f);
  endfunction

  // Ideal x[n] = 1/8 sum X[k] e^{+j 2 pi k n / 8}, rounded and clamped
  function automatic vec_t model(vec_t v);
    vec_t o;
    real a, sr, si;
    o = v;
    for (int n = 0; n < 8; n++) begin
      sr = 0.0; si = 0.0;
      for (int k = 0; k < 8; k++) begin
        a = 2.0 * 3.141592653589793 * real'(k * n) / 8.0;
        sr += real'(v.xr[k]) * $cos(a) - real'(v.xi[k]) * $sin(a);
        si += real'(v.xr[k]) * $sin(a) + real'(v.xi[k]) * $cos(a);
      end
      o.yr[n] = rsat(sr / 8.0);
      o.yi[n] = rsat(si / 8.0);
    end
    return o;
  endfunction

  always @(negedge clk) begin : mon
    sb_t e;
    if (done) begin
      n_done++;
      chk("done_pulse", prev_done, 0, 0);
      chk("busy_at_done", busy, 0, 0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0, 0);
      end else begin
        e = sbq.pop_front();
        chk({nms[e.v.id], "_lat"}, cyc - e.c0, 12, 0);
        for (int n = 0; n < 8; n++) begin
          chk($sformatf("%s_re%0d", nms[e.v.id], n),
              longint'($signed(re_out[n*DW +: DW])), e.v.yr[n], e.v.tol);
          chk($sformatf("%s_im%0d", nms[e.v.id], n),
              longint'($signed(im_out[n*DW +: DW])), e.v.yi[n], e.v.tol);
        end
      end
    end
    prev_done = done;
  end

  task automatic drive(vec_t v);
    for (int k = 0; k < 8; k++) begin
      re_in[k*DW +: DW] = DW'(v.xr[k]);
      im_in[k*DW +: DW] = DW'(v.xi[k]);
    end
  endtask

  // Returns at the falling edge just after the start-capture edge
  task automatic launch(vec_t v, bit push);
    sb_t e;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.v = v;
      e.c0 = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int n0, int lim);
    int k;
    k = 0;
    while (n_done <= n0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (n_done <= n0) begin
      total++;
      bad++;
      $display("FAIL timeout: done count %0d want >%0d", n_done, n0);
    end
  endtask

  task automatic run(vec_t v);
    int n0;
    n0 = n_done;
    launch(v, 1'b1);
    wait_done(n0, 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sr[8];
    int si[8];
    int n0, c0;
    sb_t e;

    rst = 1'b1;
    start = 1'b0;
    re_in = '0;
    im_in = '0;

    for (int i = 0; i < 8; i++) tab[i] = mk(i, 2);
    tab[0].tol = 0;
    tab[0].xr[0] = 8000;
    tab[1].tol = 0;
    tab[1].xi[0] = 8000;
    for (int k = 0; k < 8; k++) tab[2].xr[k] = 1024;
    tab[3].xr[1] = 8192;
    tab[4].xr[7] = 8192;
    for (int k = 0; k < 8; k++) tab[5].xr[k] = -32768;
    sr = '{32767, 32767, 0, -32767, -32767, -32767, 0, 32767};
    si = '{0, -32767, -32767, -32767, 0, 32767, 32767, 32767};
    tab[6].tol = 3;
    for (int k = 0; k < 8; k++) begin
      tab[6].xr[k] = sr[k];
      tab[6].xi[k] = si[k];
    end
    tab[7].tol = 3;
    for (int k = 0; k < 8; k++) begin
      tab[7].xr[k] = int'($urandom_range(8000)) - 4000;
      tab[7].xi[k] = int'($urandom_range(8000)) - 4000;
    end
    for (int i = 0; i < 8; i++) tab[i] = model(tab[i]);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_re_out", (re_out != '0), 0, 0);
    chk("rst_im_out", (im_out != '0), 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done, 0, 0);
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", busy, 0, 0);
    start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run(tab[i]);

    // start pulsed at E5 with other data must be ignored
    n0 = n_done;
    launch(tab[0], 1'b1);
    repeat (4) @(negedge clk);
    drive(tab[3]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, 40);
    repeat (15) @(negedge clk);
    chk("ignored_start_dones", n_done, n0 + 1, 0);

    // reset at E6 aborts the transform and clears outputs
    n0 = n_done;
    launch(tab[3], 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done, n0, 0);
    chk("abort_re_out", (re_out != '0), 0, 0);
    chk("abort_im_out", (im_out != '0), 0, 0);
    chk("abort_busy", busy, 0, 0);

    run(tab[3]);

    // start held high: second transform captured at E13
    n0 = n_done;
    @(negedge clk);
    drive(tab[0]);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    e.v = tab[0];
    e.c0 = c0;
    sbq.push_back(e);
    e.c0 = c0 + 13;
    sbq.push_back(e);
    repeat (14) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n0 + 1, 60);
    chk("b2b_dones", n_done, n0 + 2, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
